mult_shift_add: RTL and testbench
=================================

MULT_SHIFT_ADD -- requirements
Module: mult_shift_add

Interface
REQ-001 Parameter: WIDTH, 12, operand width in bits; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 x_parallel  input  WIDTH  multiplicand, from upstream shift_in deserializer.
REQ-005 fx  input  1  multiplicand-ready flag from upstream deserializer.
REQ-006 y_parallel  input  WIDTH  multiplier, from second upstream deserializer.
REQ-007 fy  input  1  multiplier-ready flag from second deserializer.
REQ-008 product  output  2*WIDTH  registered unsigned product x*y.
REQ-009 busy  output  1  high while a multiplication is in progress.
REQ-010 done  output  1  high while product holds a completed result not yet released.

Function
REQ-011 go = fx & fy; block SHALL use only go, not fx or fy separately.
REQ-012 FSM states SHALL be IDLE, RUN, DONE.
REQ-013 IDLE: edge with go=1 SHALL capture x_parallel into multiplicand register, zero-extended to 2*WIDTH; capture y_parallel into multiplier register; clear accumulator; clear iteration counter; go to RUN.
REQ-014 IDLE with go=0 SHALL hold all registers.
REQ-015 RUN, each edge: if multiplier[0]=1, accumulator SHALL add multiplicand modulo 2^(2*WIDTH); multiplicand SHALL shift left by 1; multiplier SHALL shift right by 1; counter SHALL increment.
REQ-016 RUN edge on which counter reaches WIDTH SHALL load product from final accumulator value, set done=1, clear busy, go to DONE.
REQ-017 Latency: done SHALL rise exactly WIDTH edges after the capture edge (12 for default).
REQ-018 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-019 Operand or go changes during RUN SHALL be ignored; the operation completes on captured values.
REQ-020 DONE SHALL hold product and done=1 while go=1; the edge with go=0 SHALL return to IDLE and clear done.
REQ-021 Rearm rule: go held continuously high across completion SHALL NOT start a second multiplication.
REQ-022 product SHALL keep its last value in IDLE and RUN and change only on entry to DONE.
REQ-023 Arithmetic SHALL be unsigned and exact; 2*WIDTH bits SHALL hold any result without overflow.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE and clear product, busy, done, counter, accumulator and operand registers to 0.
REQ-025 reset SHALL take priority over every other event, including mid-RUN and go=1 on the same edge.
REQ-026 After reset releases, go already high SHALL start a multiplication on the first edge with reset=0.

Configuration
REQ-027 Macro MULT_EARLY_EXIT_EN SHALL select the termination rule for RUN.
REQ-028 With MULT_EARLY_EXIT_EN defined: a RUN edge that sees multiplier register = 0 SHALL, instead of processing a bit, load product from the accumulator and go to DONE. Latency = (index of highest set bit of y)+2 edges; y=0 gives 1 edge.
REQ-029 Without the macro: latency SHALL always be WIDTH edges per REQ-017; no zero detection logic SHALL be present.
REQ-030 Product values SHALL be identical in both builds.

Verification
REQ-031 x=4095, y=4095, go pulse held until done → product=0xFFE001 (16769025); done rises 12 edges after capture (no macro).
REQ-032 x=3, y=5 → product=15; busy high for exactly 12 cycles; done held until go drops, then IDLE with product still 15.
REQ-033 x=1234, y=0 → product=0; no macro: done after 12 edges; with MULT_EARLY_EXIT_EN: done after 1 edge.
REQ-034 x=1, y=1 with MULT_EARLY_EXIT_EN → product=1, done after 2 edges; y=0x800 → done after 13 edges, product=0x800.
REQ-035 Reset asserted on the 6th RUN edge of 100*200 → product=0, busy=0, done=0 next cycle; a new run of 100*200 completes with 20000.
REQ-036 go held high for 40 cycles after one capture → exactly one completion; done stays 1; no busy re-assertion.

Source files
------------

// File: rtl/mult_shift_add_if.sv
// ---------------------------------------------------------------------------
// mult_shift_add_if
//
// Purpose:
//   Groups the operand, flag and result signals of the shift-and-add
//   multiplier into one bundle. The upstream side (the two deserializers
//   plus whatever consumes the result) uses the master modport, and the
//   multiplier itself uses the slave modport.
//
// Signals:
//   x_parallel  [WIDTH-1:0]    multiplicand from the first deserializer
//   fx                         multiplicand-ready flag
//   y_parallel  [WIDTH-1:0]    multiplier from the second deserializer
//   fy                         multiplier-ready flag
//   product     [2*WIDTH-1:0]  registered unsigned product
//   busy                       a multiplication is in progress
//   done                       product holds a completed, unreleased result
// ---------------------------------------------------------------------------
interface mult_shift_add_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0]   x_parallel;
    logic               fx;
    logic [WIDTH-1:0]   y_parallel;
    logic               fy;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    // Drives operands and flags, observes the result.
    modport master (
        output x_parallel,
        output fx,
        output y_parallel,
        output fy,
        input  product,
        input  busy,
        input  done
    );

    // The multiplier: consumes operands and flags, produces the result.
    modport slave (
        input  x_parallel,
        input  fx,
        input  y_parallel,
        input  fy,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/mult_shift_add.sv
// ---------------------------------------------------------------------------
// mult_shift_add
//
// Purpose:
//   Sequential unsigned shift-and-add multiplier. When both upstream
//   deserializers flag their operands ready (go = fx & fy), the operands
//   are captured, one multiplier bit is processed per clock, and the exact
//   2*WIDTH-bit product is presented with done held high until go drops.
//
// Ports:
//   clk     single clock, all state changes on its rising edge
//   reset   synchronous active-high reset, has priority over everything
//   bus     mult_shift_add_if.slave
//             x_parallel / fx  multiplicand and its ready flag
//             y_parallel / fy  multiplier and its ready flag
//             product          registered product, changes only on entry
//                              to DONE
//             busy             high in RUN only
//             done             high in DONE only
//
// Configuration:
//   MULT_EARLY_EXIT_EN  when defined, RUN terminates as soon as the shifted
//                       multiplier register is zero, so latency depends on
//                       the highest set bit of y. When undefined (default),
//                       RUN always takes exactly WIDTH edges and there is no
//                       zero-detect logic at all. The product is the same in
//                       both builds.
// ---------------------------------------------------------------------------
module mult_shift_add #(
    parameter int WIDTH = 12
) (
    input  logic          clk,
    input  logic          reset,
    mult_shift_add_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [2*WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               go;
    logic [2*WIDTH-1:0] acc_next;

    // The two ready flags only matter in combination.
    assign go = bus.fx & bus.fy;

    // Partial-product accumulation for the current multiplier bit. The
    // accumulator is 2*WIDTH bits wide, so it can never overflow for
    // WIDTH-bit operands.
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // State register and datapath registers. Reset clears everything and
    // wins over any go or RUN activity on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath control. Everything holds by default, so IDLE
    // without go and DONE with go both leave the registers untouched, and
    // operand/flag activity during RUN is simply never looked at.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.x_parallel};
                    mplier_d = bus.y_parallel;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
`ifdef MULT_EARLY_EXIT_EN
                // Once every set multiplier bit has been consumed the
                // accumulator already holds the final product.
                if (mplier_q == '0) begin
                    product_d = acc_q;
                    state_d   = DONE;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
`else
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The last bit is folded in on the same edge that loads
                // the product, hence acc_next rather than acc_q.
                if (cnt_d == CNT_LAST) begin
                    product_d = acc_next;
                    state_d   = DONE;
                end
`endif
            end

            DONE: begin
                // go must drop before another capture can happen, so a
                // flag held high across completion never re-arms.
                if (!go) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.product = product_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_mult_shift_add.sv
// ---------------------------------------------------------------------------
// tb_mult_shift_add
//
// Self-checking bench for mult_shift_add. Directed operand pairs with
// hand-computed products and latencies are driven through the interface;
// each issued multiplication pushes its expectation into a scoreboard
// queue, and an independent monitor pops and checks product, latency and
// busy duration whenever done rises. Latencies follow MULT_EARLY_EXIT_EN
// when the bench is built with that macro.
// ---------------------------------------------------------------------------
module tb_mult_shift_add;

    localparam int WIDTH = 12;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 lat;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0]   x;
        logic [WIDTH-1:0]   y;
        logic [2*WIDTH-1:0] prod;
        int                 lat_default;
        int                 lat_early;
    } vec_t;

    logic clk;
    logic reset;

    mult_shift_add_if #(.WIDTH(WIDTH)) bus ();

    mult_shift_add #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  sb[$];
    int    check_count = 0;
    int    pass_count  = 0;
    int    cycle       = 0;
    logic [2*WIDTH-1:0] last_product;
    vec_t  vecs[7];

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used by the monitor to measure latency.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    function automatic int pickLatency(input vec_t v);
`ifdef MULT_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat_default;
`endif
    endfunction

    // Monitor: timestamps the capture edge from busy rising, counts busy
    // cycles, and on every rising done pops the scoreboard and compares.
    int   cap_cycle   = 0;
    int   busy_cycles = 0;
    logic prev_busy   = 1'b0;
    logic prev_done   = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy && !prev_busy) begin
            cap_cycle   = cycle;
            busy_cycles = 0;
        end
        if (bus.busy) begin
            busy_cycles++;
        end
        if (bus.done && !prev_done) begin
            if (sb.size() == 0) begin
                check_count++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no completion",
                         cycle);
            end else begin
                e = sb.pop_front();
                checkOutput("mon_product", 32'(bus.product), 32'(e.prod));
                checkOutput("mon_latency", 32'(cycle - cap_cycle), 32'(e.lat));
                checkOutput("mon_busy_cycles", 32'(busy_cycles), 32'(e.lat));
            end
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    // Bounded wait for done, checked at negedges.
    task automatic waitDone();
        for (int i = 0; i < 40; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        checkOutput("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // One full transaction: capture, disturb operands and flags during RUN,
    // hold go through DONE for hold_cycles, then release.
    task automatic applyStimulus(input vec_t v, input int hold_cycles);
        int bad_busy;
        exp_t e;
        e.prod = v.prod;
        e.lat  = pickLatency(v);
        sb.push_back(e);
        bus.x_parallel = v.x;
        bus.y_parallel = v.y;
        bus.fx = 1'b1;
        bus.fy = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_capture", 32'(bus.busy), 32'd1);
        checkOutput("product_held_in_run", 32'(bus.product), 32'(last_product));
        bus.x_parallel = WIDTH'($urandom);
        bus.y_parallel = WIDTH'($urandom);
        bus.fy = 1'b0;
        @(negedge clk);
        bus.fy = 1'b1;
        waitDone();
        bad_busy = 0;
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            if (bus.busy || !bus.done) bad_busy++;
        end
        checkOutput("done_hold_stable", 32'(bad_busy), 32'd0);
        checkOutput("product_in_done", 32'(bus.product), 32'(v.prod));
        bus.fx = 1'b0;
        bus.fy = 1'b0;
        @(negedge clk);
        checkOutput("done_cleared", 32'(bus.done), 32'd0);
        checkOutput("idle_not_busy", 32'(bus.busy), 32'd0);
        checkOutput("product_kept_idle", 32'(bus.product), 32'(v.prod));
        last_product = v.prod;
    endtask

    // Main sequence.
    initial begin
        exp_t e;
        vecs[0] = '{12'd4095,  12'd4095,  24'd16769025, 12, 13};
        vecs[1] = '{12'd3,     12'd5,     24'd15,       12, 4};
        vecs[2] = '{12'd1234,  12'd0,     24'd0,        12, 1};
        vecs[3] = '{12'd1,     12'd1,     24'd1,        12, 2};
        vecs[4] = '{12'd1,     12'h800,   24'h000800,   12, 13};
        vecs[5] = '{12'hABC,   12'h123,   24'd799668,   12, 10};
        vecs[6] = '{12'h800,   12'h800,   24'h400000,   12, 13};

        reset = 1'b1;
        bus.x_parallel = 12'd77;
        bus.y_parallel = 12'd55;
        bus.fx = 1'b0;
        bus.fy = 1'b0;
        last_product = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_product", 32'(bus.product), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);

        // Only one flag high: go stays low, nothing starts.
        reset = 1'b0;
        bus.fx = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_one_flag_busy", 32'(bus.busy), 32'd0);
        checkOutput("idle_one_flag_product", 32'(bus.product), 32'd0);
        bus.fx = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], (i == 1) ? 40 : 2);
        end

        // Reset on the 6th RUN edge of 100*200, with go still high.
        bus.x_parallel = 12'd100;
        bus.y_parallel = 12'd200;
        bus.fx = 1'b1;
        bus.fy = 1'b1;
        @(negedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_product", 32'(bus.product), 32'd0);
        checkOutput("midrun_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrun_reset_done", 32'(bus.done), 32'd0);

        // go already high at release starts straight away.
        e.prod = 24'd20000;
`ifdef MULT_EARLY_EXIT_EN
        e.lat = 9;
`else
        e.lat = 12;
`endif
        sb.push_back(e);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("restart_busy", 32'(bus.busy), 32'd1);
        waitDone();
        checkOutput("restart_product", 32'(bus.product), 32'd20000);
        bus.fx = 1'b0;
        bus.fy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
